// File: rtl/innings_scorekeeper_pkg.sv
// Shared event codes, FSM states and defaults for the innings scorekeeper.
// Decoded event bundle passed from the top level to the per-team tallies.
package innings_scorekeeper_pkg;

  localparam int MAX_BALLS_DEF   = 120;
  localparam int MAX_WICKETS_DEF = 10;
  localparam int RUN_MAX_DEF     = 255;

  localparam logic [3:0] EV_DOT    = 4'd0;
  localparam logic [3:0] EV_ONE    = 4'd1;
  localparam logic [3:0] EV_TWO    = 4'd2;
  localparam logic [3:0] EV_THREE  = 4'd3;
  localparam logic [3:0] EV_FOUR   = 4'd4;
  localparam logic [3:0] EV_SIX    = 4'd6;
  localparam logic [3:0] EV_WIDE   = 4'd8;
  localparam logic [3:0] EV_NOBALL = 4'd9;
  localparam logic [3:0] EV_WICKET = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BAT1,
    S_BREAK,
    S_BAT2,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] runs;
    logic       wkt;
    logic       ball;
  } ev_t;

  function automatic ev_t ev_decode(input logic [3:0] code);
    ev_t d;
    d = '0;
    case (code)
      EV_DOT: begin
        d.ok   = 1'b1;
        d.ball = 1'b1;
      end
      EV_ONE, EV_TWO, EV_THREE,
      EV_FOUR, EV_SIX: begin
        d.ok   = 1'b1;
        d.runs = code[2:0];
        d.ball = 1'b1;
      end
      EV_WIDE, EV_NOBALL: begin
        d.ok   = 1'b1;
        d.runs = 3'd1;
      end
      EV_WICKET: begin
        d.ok   = 1'b1;
        d.wkt  = 1'b1;
        d.ball = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/innings_scorekeeper_team_tally.sv
// One team's runs/wickets/balls with saturating increments.
// Load port restores an undo snapshot; en applies one decoded event.
module innings_scorekeeper_team_tally #(
  parameter int MAX_BALLS   = 120,
  parameter int MAX_WICKETS = 10,
  parameter int RUN_MAX     = 255
) (
  input  logic       clk_fpga,
  input  logic       reset_n,
  input  logic       en,
  input  logic [2:0] add_runs,
  input  logic       add_wkt,
  input  logic       add_ball,
  input  logic       load,
  input  logic [7:0] ld_runs,
  input  logic [3:0] ld_wkts,
  input  logic [6:0] ld_balls,
  output logic [7:0] runs,
  output logic [3:0] wkts,
  output logic [6:0] balls,
  output logic [3:0] wkts_nxt,
  output logic [6:0] balls_nxt
);

  logic [8:0] run_sum;
  logic [7:0] runs_nxt;

  // Post-event values, clamped at their limits
  always_comb begin
    run_sum  = {1'b0, runs} + {6'd0, add_runs};
    runs_nxt = (run_sum > 9'(RUN_MAX)) ? 8'(RUN_MAX)
                                       : run_sum[7:0];
    wkts_nxt = wkts;
    if (add_wkt && wkts != 4'(MAX_WICKETS))
      wkts_nxt = wkts + 4'd1;
    balls_nxt = balls;
    if (add_ball && balls != 7'(MAX_BALLS))
      balls_nxt = balls + 7'd1;
  end

  // Counter registers: undo load beats event update
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      runs  <= '0;
      wkts  <= '0;
      balls <= '0;
    end else if (load) begin
      runs  <= ld_runs;
      wkts  <= ld_wkts;
      balls <= ld_balls;
    end else if (en) begin
      runs  <= runs_nxt;
      wkts  <= wkts_nxt;
      balls <= balls_nxt;
    end
  end

endmodule

// File: rtl/innings_scorekeeper.sv
// Innings sequencing, event decode and output muxing for two teams.
// Optional one-deep undo enabled by defining UNDO_ENABLE_EN.
module innings_scorekeeper
  import innings_scorekeeper_pkg::*;
#(
  parameter int MAX_BALLS   = MAX_BALLS_DEF,
  parameter int MAX_WICKETS = MAX_WICKETS_DEF,
  parameter int RUN_MAX     = RUN_MAX_DEF
) (
  input  logic        clk_fpga,
  input  logic        reset_n,
  input  logic        start,
  input  logic        next_innings,
  input  logic        event_valid,
  input  logic [3:0]  event_code,
  input  logic        undo,
  output logic        event_ready,
  output logic [11:0] team1Data,
  output logic [11:0] team2Data,
  output logic [6:0]  team1Balls,
  output logic [6:0]  team2Balls,
  output logic [3:0]  wickets,
  output logic [15:0] balls,
  output logic        batting_team,
  output logic        undo_avail
);

  state_t state, state_nxt;
  ev_t    ev;

  logic       accept, inn_end, undo_eff;
  logic       en1, en2, ld1, ld2;
  logic [7:0] r1, r2, bat_r;
  logic [3:0] w1, w2, w1n, w2n, bat_w, bat_wn;
  logic [6:0] b1, b2, b1n, b2n, bat_b, bat_bn;

  logic [7:0] ld_runs;
  logic [3:0] ld_wkts;
  logic [6:0] ld_balls;
  state_t     snap_state;

  assign ev = ev_decode(event_code);

  assign accept = event_valid & event_ready
                & ev.ok & ~undo_eff;

  assign bat_r  = batting_team ? r2  : r1;
  assign bat_w  = batting_team ? w2  : w1;
  assign bat_b  = batting_team ? b2  : b1;
  assign bat_wn = batting_team ? w2n : w1n;
  assign bat_bn = batting_team ? b2n : b1n;

  assign inn_end = accept
                 & ((bat_wn == 4'(MAX_WICKETS))
                  | (bat_bn == 7'(MAX_BALLS)));

  assign en1 = accept & (state == S_BAT1);
  assign en2 = accept & (state == S_BAT2);
  assign ld1 = undo_eff & (snap_state == S_BAT1);
  assign ld2 = undo_eff & (snap_state == S_BAT2);

`ifdef UNDO_ENABLE_EN
  logic snap_valid;

  assign undo_eff   = undo & snap_valid
                    & ~((state == S_BREAK) & next_innings);
  assign undo_avail = snap_valid;

  // One-deep snapshot of the batting team before each accepted event
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      snap_valid <= 1'b0;
      snap_state <= S_IDLE;
      ld_runs    <= '0;
      ld_wkts    <= '0;
      ld_balls   <= '0;
    end else if ((state == S_BREAK) && next_innings) begin
      snap_valid <= 1'b0;
    end else if (undo_eff) begin
      snap_valid <= 1'b0;
    end else if (accept) begin
      snap_valid <= 1'b1;
      snap_state <= state;
      ld_runs    <= bat_r;
      ld_wkts    <= bat_w;
      ld_balls   <= bat_b;
    end
  end
`else
  logic unused_undo;

  assign unused_undo = ^{undo, bat_r, bat_w};
  assign undo_eff    = 1'b0;
  assign undo_avail  = 1'b0;
  assign snap_state  = S_IDLE;
  assign ld_runs     = '0;
  assign ld_wkts     = '0;
  assign ld_balls    = '0;
`endif

  innings_scorekeeper_team_tally #(
    .MAX_BALLS   (MAX_BALLS),
    .MAX_WICKETS (MAX_WICKETS),
    .RUN_MAX     (RUN_MAX)
  ) u_tally1 (
    .clk_fpga  (clk_fpga),
    .reset_n   (reset_n),
    .en        (en1),
    .add_runs  (ev.runs),
    .add_wkt   (ev.wkt),
    .add_ball  (ev.ball),
    .load      (ld1),
    .ld_runs   (ld_runs),
    .ld_wkts   (ld_wkts),
    .ld_balls  (ld_balls),
    .runs      (r1),
    .wkts      (w1),
    .balls     (b1),
    .wkts_nxt  (w1n),
    .balls_nxt (b1n)
  );

  innings_scorekeeper_team_tally #(
    .MAX_BALLS   (MAX_BALLS),
    .MAX_WICKETS (MAX_WICKETS),
    .RUN_MAX     (RUN_MAX)
  ) u_tally2 (
    .clk_fpga  (clk_fpga),
    .reset_n   (reset_n),
    .en        (en2),
    .add_runs  (ev.runs),
    .add_wkt   (ev.wkt),
    .add_ball  (ev.ball),
    .load      (ld2),
    .ld_runs   (ld_runs),
    .ld_wkts   (ld_wkts),
    .ld_balls  (ld_balls),
    .runs      (r2),
    .wkts      (w2),
    .balls     (b2),
    .wkts_nxt  (w2n),
    .balls_nxt (b2n)
  );

  // State register
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state: undo rewinds to the snapshot state
  always_comb begin
    state_nxt = state;
    if (undo_eff) begin
      state_nxt = snap_state;
    end else begin
      case (state)
        S_IDLE:  if (start)        state_nxt = S_BAT1;
        S_BAT1:  if (inn_end)      state_nxt = S_BREAK;
        S_BREAK: if (next_innings) state_nxt = S_BAT2;
        S_BAT2:  if (inn_end)      state_nxt = S_DONE;
        S_DONE:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Moore outputs from the current state
  always_comb begin
    event_ready  = (state == S_BAT1) | (state == S_BAT2);
    batting_team = (state == S_BAT2) | (state == S_DONE);
  end

  assign team1Data  = {r1, w1};
  assign team2Data  = {r2, w2};
  assign team1Balls = b1;
  assign team2Balls = b2;
  assign wickets    = bat_w;
  assign balls      = {9'd0, bat_b};

endmodule
